// File: rtl/nmc_accum_act.sv
// Accumulates DIM partial-sum lanes over a group of beats with per-lane saturation,
// then requantises (arithmetic shift) and applies ReLU or signed clamp to produce OUT_W-bit lanes.
module nmc_accum_act #(
    parameter int IN_W   = 18,
    parameter int ACC_W  = 21,
    parameter int OUT_W  = 4,
    parameter int DIM    = 64,
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W*DIM-1:0]   in_data,
    input  logic [7:0]            acc_len,
    input  logic [4:0]            shift,
    input  logic                  relu_en,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W*DIM-1:0]  out_data,
    output logic [ADDR_W-1:0]     out_addr,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;
    typedef enum logic [1:0] {ACC_HOLD, ACC_LOAD, ACC_ADD, ACC_CLEAR} acc_op_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] U_MAX   = ACC_W'((1 << OUT_W) - 1);
    localparam logic signed [ACC_W-1:0] S_MAX   = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] S_MIN   = ~S_MAX;

    state_t              state_q, state_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [4:0]          shift_q, shift_d;
    logic                relu_q, relu_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    acc_op_t             acc_op;
    logic                load_out;

    assign in_ready  = (state_q != S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign out_addr  = addr_q;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        relu_d   = relu_q;
        addr_d   = addr_q;
        acc_op   = ACC_HOLD;
        load_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Group configuration is captured from the opening beat only; flush is ignored here.
                if (in_valid) begin
                    len_d   = (acc_len == 8'd0) ? 8'd1 : acc_len;
                    shift_d = shift;
                    relu_d  = relu_en;
                    cnt_d   = 8'd1;
                    acc_op  = ACC_LOAD;
                    if (len_d == 8'd1) begin
                        state_d  = S_OUT;
                        load_out = 1'b1;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    acc_op = ACC_ADD;
                    cnt_d  = cnt_q + 8'd1;
                end
                if ((in_valid && (cnt_d == len_q)) || flush) begin
                    state_d  = S_OUT;
                    load_out = 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    acc_op  = ACC_CLEAR;
                    cnt_d   = 8'd0;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= 8'd1;
            cnt_q   <= 8'd0;
            shift_q <= 5'd0;
            relu_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
            addr_q  <= addr_d;
        end
    end

    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
        logic signed [IN_W-1:0]  lane_in;
        logic signed [ACC_W-1:0] lane_ext;
        logic signed [ACC_W:0]   sum;
        logic signed [ACC_W-1:0] acc_q, acc_d;
        logic signed [ACC_W-1:0] shifted;
        logic [OUT_W-1:0]        act;
        logic [OUT_W-1:0]        out_q, out_d;

        assign lane_in  = in_data[IN_W*gi +: IN_W];
        assign lane_ext = ACC_W'(lane_in);
        assign sum      = (ACC_W+1)'(acc_q) + (ACC_W+1)'(lane_ext);

        always_comb begin
            acc_d = acc_q;
            case (acc_op)
                ACC_LOAD:  acc_d = lane_ext;
                ACC_ADD: begin
                    // The two top bits of the widened sum disagree exactly on overflow.
                    if (sum[ACC_W] != sum[ACC_W-1]) begin
                        acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                end
                ACC_CLEAR: acc_d = '0;
                default:   acc_d = acc_q;
            endcase
        end

        // Activation sees the post-update accumulator so the closing beat is included.
        assign shifted = acc_d >>> shift_d;

        always_comb begin
            act = shifted[OUT_W-1:0];
            if (relu_d) begin
                if (shifted[ACC_W-1]) begin
                    act = '0;
                end else if (shifted > U_MAX) begin
                    act = '1;
                end
            end else begin
                if (shifted < S_MIN) begin
                    act = S_MIN[OUT_W-1:0];
                end else if (shifted > S_MAX) begin
                    act = S_MAX[OUT_W-1:0];
                end
            end
        end

        assign out_d = load_out ? act : out_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q <= '0;
                out_q <= '0;
            end else begin
                acc_q <= acc_d;
                out_q <= out_d;
            end
        end

        assign out_data[OUT_W*gi +: OUT_W] = out_q;
    end

endmodule

// File: tb/tb_nmc_accum_act.sv
// Scoreboard bench for nmc_accum_act: a group-level reference model predicts each result,
// and an independent monitor compares every cycle the DUT presents out_valid.
`timescale 1ns/1ps
module tb_nmc_accum_act;
    localparam int IN_W   = 18;
    localparam int ACC_W  = 21;
    localparam int OUT_W  = 4;
    localparam int DIM    = 64;
    localparam int ADDR_W = 6;
    localparam int OW     = OUT_W * DIM;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [IN_W*DIM-1:0]  in_data = '0;
    logic [7:0]           acc_len = 8'd0;
    logic [4:0]           shift = 5'd0;
    logic                 relu_en = 1'b0;
    logic                 flush = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [OW-1:0]        out_data;
    logic [ADDR_W-1:0]    out_addr;
    logic                 busy;

    always #5 clk = ~clk;

    nmc_accum_act #(
        .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .DIM(DIM), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .acc_len(acc_len), .shift(shift), .relu_en(relu_en),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .busy(busy)
    );

    typedef struct {
        logic [OW-1:0]     data;
        logic [ADDR_W-1:0] addr;
        int                cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_pass = 0;
    int     cyc = 0;
    bit     seen = 0;
    bit     rand_ready = 0;

    longint m_acc[DIM];
    int     m_cnt = 0;
    int     m_len = 1;
    int     m_shift = 0;
    int     m_groups = 0;
    bit     m_relu = 0;
    bit     m_open = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [OW-1:0] act, logic [OW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic logic [OUT_W-1:0] act_f(longint v, int sh, bit relu);
        longint s;
        longint lo;
        longint hi;
        s = v >>> sh;
        if (relu) begin
            lo = 0;
            hi = (longint'(1) << OUT_W) - 1;
        end else begin
            lo = -(longint'(1) << (OUT_W - 1));
            hi = (longint'(1) << (OUT_W - 1)) - 1;
        end
        if (s < lo) s = lo;
        if (s > hi) s = hi;
        return OUT_W'(s);
    endfunction

    function automatic void m_close();
        exp_t          e;
        logic [OW-1:0] d;
        d = '0;
        for (int i = 0; i < DIM; i++) d[OUT_W*i +: OUT_W] = act_f(m_acc[i], m_shift, m_relu);
        e.data = d;
        e.addr = ADDR_W'(m_groups);
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
        m_groups++;
        m_open = 0;
    endfunction

    function automatic void m_update(bit accepted, bit fl);
        bit     was_open;
        longint amax;
        longint amin;
        amax = (longint'(1) << (ACC_W - 1)) - 1;
        amin = -(longint'(1) << (ACC_W - 1));
        was_open = m_open;
        if (accepted) begin
            if (!m_open) begin
                m_open  = 1;
                m_len   = (acc_len == 8'd0) ? 1 : int'(acc_len);
                m_shift = int'(shift);
                m_relu  = relu_en;
                m_cnt   = 0;
                for (int i = 0; i < DIM; i++) m_acc[i] = 0;
            end
            for (int i = 0; i < DIM; i++) begin
                m_acc[i] = m_acc[i] + longint'($signed(in_data[IN_W*i +: IN_W]));
                if (m_acc[i] > amax) m_acc[i] = amax;
                if (m_acc[i] < amin) m_acc[i] = amin;
            end
            m_cnt++;
            if (m_cnt == m_len || (fl && was_open)) m_close();
        end else if (fl && m_open) begin
            m_close();
        end
    endfunction

    // Inputs change 1ns after the edge; the model commits what the DUT will see at the next edge.
    task automatic step(input bit v, input bit fl);
        in_valid = v;
        flush    = fl;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        m_update(v && in_ready, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit fl);
        int tries;
        tries = 0;
        while (!in_ready && tries < 200) begin
            step(0, 0);
            tries++;
        end
        if (!in_ready) chk("in_ready_timeout", OW'(in_ready), OW'(1));
        step(1, fl);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            step(0, 0);
            t++;
        end
        chk("drain_timeout", OW'(exp_q.size()), OW'(0));
    endtask

    task automatic set_lane0(input int v);
        in_data = '0;
        in_data[IN_W-1:0] = IN_W'(v);
    endtask

    task automatic cfg(input int len, input int sh, input bit r);
        acc_len = 8'(len);
        shift   = 5'(sh);
        relu_en = r;
    endtask

    task automatic beats(input int a, input int b, input int c, input int n);
        if (n > 0) begin set_lane0(a); send(0); end
        if (n > 1) begin set_lane0(b); send(0); end
        if (n > 2) begin set_lane0(c); send(0); end
    endtask

    task automatic do_reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_out_valid"}, OW'(out_valid), OW'(0));
        chk({tag, "_busy"}, OW'(busy), OW'(0));
        chk({tag, "_out_data"}, out_data, OW'(0));
        chk({tag, "_out_addr"}, OW'(out_addr), OW'(0));
        chk({tag, "_in_ready"}, OW'(in_ready), OW'(1));
        exp_q.delete();
        seen     = 0;
        m_open   = 0;
        m_groups = 0;
        in_valid = 0;
        flush    = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                chk("in_ready_in_out", OW'(in_ready), OW'(0));
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", OW'(out_valid), OW'(0));
                end else begin
                    if (!seen) chk("out_latency", OW'(cyc), OW'(exp_q[0].cyc));
                    seen = 1;
                    chk("out_data", out_data, exp_q[0].data);
                    chk("out_addr", OW'(out_addr), OW'(exp_q[0].addr));
                    if (out_ready) begin
                        $display("txn addr=%0d data=%h", out_addr, out_data);
                        void'(exp_q.pop_front());
                        seen = 0;
                    end
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
                chk("out_valid_late", OW'(out_valid), OW'(1));
                void'(exp_q.pop_front());
                seen = 0;
            end
        end
    end

    initial begin
        int target;
        int guard;
        @(posedge clk);
        #1;
        do_reset_check("rst_init");
        out_ready = 1'b1;

        cfg(3, 0, 1); beats(1, 2, 3, 3); drain();
        cfg(1, 0, 1); beats(-5, 0, 0, 1); drain();
        cfg(1, 0, 0); beats(-5, 0, 0, 1); drain();
        cfg(2, 0, 0); beats(10, 10, 0, 2); drain();
        cfg(0, 0, 1); beats(9, 0, 0, 1); drain();
        cfg(2, 3, 1); beats(50, 50, 0, 2); drain();
        cfg(1, 2, 1); beats(100, 0, 0, 1); drain();

        cfg(16, 17, 0);
        set_lane0(131071);
        for (int i = 0; i < 16; i++) send(0);
        drain();
        cfg(16, 17, 0);
        set_lane0(-131072);
        for (int i = 0; i < 16; i++) send(0);
        drain();

        // Config changes mid-group must not take effect
        cfg(3, 0, 1); set_lane0(2); send(0);
        cfg(1, 5, 0); set_lane0(3); send(0); set_lane0(4); send(0);
        drain();

        cfg(8, 0, 1); beats(1, 2, 0, 2); set_lane0(3); send(1); drain();
        cfg(8, 0, 1); beats(2, 3, 0, 2); step(0, 1); drain();
        cfg(3, 0, 1); set_lane0(1); send(1); beats(1, 1, 0, 2); drain();

        out_ready = 1'b0;
        cfg(2, 0, 0); beats(-3, 1, 0, 2);
        for (int i = 0; i < 7; i++) step(0, 0);
        out_ready = 1'b1;
        drain();

        cfg(4, 0, 1); beats(100, 100, 0, 2);
        do_reset_check("rst_accum");
        cfg(2, 0, 1); beats(3, 4, 0, 2); drain();
        out_ready = 1'b0;
        cfg(1, 0, 1); beats(11, 0, 0, 1);
        step(0, 0); step(0, 0);
        do_reset_check("rst_out");
        out_ready = 1'b1;
        cfg(2, 0, 0); beats(1, 2, 0, 2); drain();

        rand_ready = 1;
        for (int g = 0; g < 90; g++) begin
            target = m_groups + 1;
            guard = 0;
            while (m_groups < target && guard < 500) begin
                cfg($urandom_range(0, 6), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
                for (int i = 0; i < DIM; i++) in_data[IN_W*i +: IN_W] = IN_W'($urandom);
                if ($urandom_range(0, 3) == 0) step(0, $urandom_range(0, 7) == 0);
                else send($urandom_range(0, 7) == 0);
                guard++;
            end
        end
        rand_ready = 0;
        out_ready = 1'b1;
        drain();
        step(0, 0);
        step(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
